// File: rtl/uart_frame_tx.sv
// UART frame transmitter: sends up to N_MAX characters back to back per
// frame, fetching each byte by index from a combinational source.
module uart_frame_tx #(
   parameter int unsigned CLK_DIV   = 434,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned N_MAX     = 3,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1,
   localparam int unsigned NB_W     = $clog2(N_MAX + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_st,
   input  logic [NB_W-1:0]   i_n_byte,
   input  logic              i_abort,
   input  logic [DATA_W-1:0] i_byte_dat,
   output logic [NB_W-1:0]   o_byte_idx,
   output logic              o_txd,
   output logic              o_en_tx,
   output logic              o_done
);

   localparam int unsigned TMR_W = $clog2(CLK_DIV);
   localparam int unsigned BC_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   state_t              r_state, w_state;
   logic [TMR_W-1:0]    r_timer, w_timer;
   logic [DATA_W-1:0]   r_sr, w_sr;
   logic                r_par, w_par;
   logic [BC_W-1:0]     r_bit_cnt, w_bit_cnt;
   logic [NB_W-1:0]     r_nb, w_nb;
   logic [NB_W-1:0]     r_idx, w_idx;
   logic                r_txd, w_txd;
   logic                r_en, w_en;
   logic                r_done, w_done;
   logic                w_ce_bit;
   logic                w_load;

   assign o_byte_idx = r_idx;
   assign o_txd      = r_txd;
   assign o_en_tx    = r_en;
   assign o_done     = r_done;

   // State and datapath registers; reset parks the line idle-high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_sr      <= '0;
         r_par     <= 1'b0;
         r_bit_cnt <= '0;
         r_nb      <= '0;
         r_idx     <= '0;
         r_txd     <= 1'b1;
         r_en      <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_timer   <= w_timer;
         r_sr      <= w_sr;
         r_par     <= w_par;
         r_bit_cnt <= w_bit_cnt;
         r_nb      <= w_nb;
         r_idx     <= w_idx;
         r_txd     <= w_txd;
         r_en      <= w_en;
         r_done    <= w_done;
      end
   end

   // Next-state and next-value logic; TXD is derived from the next state so it leaves a flop.
   always_comb begin
      w_ce_bit  = (r_timer == TMR_W'(CLK_DIV - 1));
      w_state   = r_state;
      w_timer   = w_ce_bit ? '0 : r_timer + TMR_W'(1);
      w_sr      = r_sr;
      w_par     = r_par;
      w_bit_cnt = r_bit_cnt;
      w_nb      = r_nb;
      w_idx     = r_idx;
      w_en      = r_en;
      w_done    = 1'b0;
      w_load    = 1'b0;
      w_txd     = 1'b1;

      case (r_state)
         S_IDLE: begin
            w_timer = '0;
            if (!i_abort && i_st && (i_n_byte != '0)) begin
               w_state = S_START;
               w_nb    = (i_n_byte > NB_W'(N_MAX)) ? NB_W'(N_MAX) : i_n_byte;
               w_en    = 1'b1;
               w_load  = 1'b1;
            end
         end
         S_START: begin
            if (w_ce_bit) w_state = S_DATA;
         end
         S_DATA: begin
            if (w_ce_bit) begin
               if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
                  w_state = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  w_bit_cnt = r_bit_cnt + BC_W'(1);
                  w_sr      = r_sr >> 1;
               end
            end
         end
         S_PAR: begin
            if (w_ce_bit) w_state = S_STOP;
         end
         S_STOP: begin
            if (w_ce_bit) begin
               if (r_bit_cnt == BC_W'(STOP_BITS - 1)) begin
                  if (r_idx == r_nb) begin
                     w_state = S_IDLE;
                     w_en    = 1'b0;
                     w_idx   = '0;
                     w_done  = 1'b1;
                  end else begin
                     w_state = S_START;
                     w_load  = 1'b1;
                  end
               end else begin
                  w_bit_cnt = r_bit_cnt + BC_W'(1);
               end
            end
         end
         default: w_state = S_IDLE;
      endcase

      // Cancel overrides any progress, silently.
      if ((r_state != S_IDLE) && i_abort) begin
         w_state = S_IDLE;
         w_en    = 1'b0;
         w_idx   = '0;
         w_done  = 1'b0;
         w_load  = 1'b0;
      end

      // Character fetch on every START entry; parity is taken from the unshifted byte.
      if (w_load) begin
         w_sr  = i_byte_dat;
         w_par = (^i_byte_dat) ^ (PARITY == 2);
         w_idx = r_idx + NB_W'(1);
      end

      if (w_state != r_state) begin
         w_timer   = '0;
         w_bit_cnt = '0;
      end

      case (w_state)
         S_IDLE:  w_txd = 1'b1;
         S_START: w_txd = 1'b0;
         S_DATA:  w_txd = w_sr[0];
         S_PAR:   w_txd = w_par;
         S_STOP:  w_txd = 1'b1;
         default: w_txd = 1'b1;
      endcase
   end

endmodule
